// File: rtl/tm1638_key_reader.sv
// TM1638 key-scan reader.
// Frames one read transaction on the TM1638 3-wire bus: strobe low, the
// read-key command shifted out LSB first, a settling gap with DIO released,
// then 32 data bits clocked in LSB first. The captured word is published on
// raw and reduced to an 8-button vector on keys. The top level owns the pins
// and the tristate; this block only produces drive/enable values.
module tm1638_key_reader #(
  parameter int unsigned HALF_PERIOD = 200,
  parameter int unsigned WAIT_CYCLES = 200,
  parameter logic [7:0]  CMD_READ    = 8'h42
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] raw,
  output logic [7:0]  keys,
  output logic        stb,
  output logic        clk1,
  output logic        dio_out,
  output logic        dio_oe,
  input  logic        dio_in
);

  // One counter serves both the half-period divider and the WAIT gap, so it
  // must be wide enough for the larger of the two terminal counts.
  localparam int unsigned CNT_MAX = (HALF_PERIOD > WAIT_CYCLES) ? HALF_PERIOD : WAIT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HP_LAST   = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Ticks per phase: 8 command bits and 32 data bits, two ticks per bit.
  localparam logic [5:0] CMD_LAST_TICK  = 6'd15;
  localparam logic [5:0] READ_LAST_TICK = 6'd63;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_READ = 3'd3;
  localparam logic [2:0] ST_STOP = 3'd4;

  logic [2:0]       state_r;
  logic [CNT_W-1:0] div_r;
  logic [5:0]       tick_cnt_r;
  logic [31:0]      shift_r;

  logic tick_s;
  logic wait_end_s;
  logic fall_tick_s;
  logic last_cmd_tick_s;
  logic last_read_tick_s;
  logic accept_s;

  // Button layout of the LED&KEY board: each scan byte carries two buttons,
  // one in bit 0 and one in bit 4; everything else in the byte is unused.
  function automatic logic [7:0] decode_keys(input logic [31:0] word);
    logic [7:0] k;
    k = 8'h00;
    for (int i = 0; i < 4; i++) begin
      k[i]     = word[8*i];
      k[i + 4] = word[8*i + 4];
    end
    return k;
  endfunction

  // Divider terminal counts and bit-phase decode shared by the sequencer.
  always_comb begin
    tick_s           = 1'b0;
    wait_end_s       = 1'b0;
    fall_tick_s      = 1'b0;
    last_cmd_tick_s  = 1'b0;
    last_read_tick_s = 1'b0;
    accept_s         = 1'b0;

    if (div_r == HP_LAST) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end

    if (div_r == WAIT_LAST) begin
      wait_end_s = 1'b1;
    end else begin
      wait_end_s = 1'b0;
    end

    // Tick counter starts at 0, so even counts are the 1st, 3rd, ... ticks:
    // those drop the serial clock, the others raise it.
    if (tick_cnt_r[0] == 1'b0) begin
      fall_tick_s = 1'b1;
    end else begin
      fall_tick_s = 1'b0;
    end

    if (tick_cnt_r == CMD_LAST_TICK) begin
      last_cmd_tick_s = 1'b1;
    end else begin
      last_cmd_tick_s = 1'b0;
    end

    if (tick_cnt_r == READ_LAST_TICK) begin
      last_read_tick_s = 1'b1;
    end else begin
      last_read_tick_s = 1'b0;
    end

    // The done cycle is spent in IDLE; a request seen then is dropped so a
    // held start yields one clean idle cycle between scans.
    if ((state_r == ST_IDLE) && start && !done) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Transfer sequencer: state, divider, tick counter, pin outputs and results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      div_r      <= CNT_ZERO;
      tick_cnt_r <= 6'd0;
      shift_r    <= 32'h0000_0000;
      stb        <= 1'b1;
      clk1       <= 1'b1;
      dio_out    <= 1'b0;
      dio_oe     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      raw        <= 32'h0000_0000;
      keys       <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          div_r      <= CNT_ZERO;
          tick_cnt_r <= 6'd0;
          stb        <= 1'b1;
          clk1       <= 1'b1;
          dio_oe     <= 1'b0;
          if (accept_s) begin
            state_r <= ST_CMD;
            stb     <= 1'b0;
            dio_oe  <= 1'b1;
            dio_out <= 1'b0;
            busy    <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end

        ST_CMD: begin
          if (tick_s) begin
            div_r <= CNT_ZERO;
            if (fall_tick_s) begin
              // New command bit goes out with the falling edge so it is
              // stable for the whole low half before the device samples.
              clk1    <= 1'b0;
              dio_out <= CMD_READ[tick_cnt_r[3:1]];
            end else begin
              clk1 <= 1'b1;
            end
            if (last_cmd_tick_s) begin
              state_r    <= ST_WAIT;
              tick_cnt_r <= 6'd0;
              dio_oe     <= 1'b0;
              dio_out    <= 1'b0;
            end else begin
              tick_cnt_r <= tick_cnt_r + 6'd1;
            end
          end else begin
            div_r <= div_r + CNT_ONE;
          end
        end

        ST_WAIT: begin
          // DIO is released and the clock parked high while the device
          // turns the line around.
          clk1 <= 1'b1;
          if (wait_end_s) begin
            state_r <= ST_READ;
            div_r   <= CNT_ZERO;
          end else begin
            div_r <= div_r + CNT_ONE;
          end
        end

        ST_READ: begin
          if (tick_s) begin
            div_r <= CNT_ZERO;
            if (fall_tick_s) begin
              clk1 <= 1'b0;
            end else begin
              // Device updates DIO after the fall; capture on the rise.
              clk1                       <= 1'b1;
              shift_r[tick_cnt_r[5:1]]   <= dio_in;
            end
            if (last_read_tick_s) begin
              state_r    <= ST_STOP;
              tick_cnt_r <= 6'd0;
            end else begin
              tick_cnt_r <= tick_cnt_r + 6'd1;
            end
          end else begin
            div_r <= div_r + CNT_ONE;
          end
        end

        ST_STOP: begin
          // Hold strobe low for one more half period with the clock high,
          // then close the frame and publish the result.
          clk1 <= 1'b1;
          if (tick_s) begin
            state_r <= ST_IDLE;
            div_r   <= CNT_ZERO;
            stb     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            raw     <= shift_r;
            keys    <= decode_keys(shift_r);
          end else begin
            div_r <= div_r + CNT_ONE;
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          div_r      <= CNT_ZERO;
          tick_cnt_r <= 6'd0;
          stb        <= 1'b1;
          clk1       <= 1'b1;
          dio_out    <= 1'b0;
          dio_oe     <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Bench for tm1638_key_reader: a fast instance (HALF_PERIOD=4, WAIT_CYCLES=4)
// and a default instance, each with a TM1638 device model on its pins and a
// timeline model that gives the expected outputs for every cycle of a scan.
module tb_tm1638_key_reader;

  localparam int HF = 4;
  localparam int WF = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_v    = 2'b00;
  logic [1:0]  start_v  = 2'b00;
  logic [1:0]  dio_in_v = 2'b00;
  logic [1:0]  busy_v, done_v, stb_v, clk1_v, dout_v, oe_v;
  logic [31:0] raw_v  [2];
  logic [7:0]  keys_v [2];

  tm1638_key_reader #(.HALF_PERIOD(HF), .WAIT_CYCLES(WF)) u_fast (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .raw(raw_v[0]), .keys(keys_v[0]), .stb(stb_v[0]), .clk1(clk1_v[0]),
    .dio_out(dout_v[0]), .dio_oe(oe_v[0]), .dio_in(dio_in_v[0])
  );

  tm1638_key_reader u_dflt (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .raw(raw_v[1]), .keys(keys_v[1]), .stb(stb_v[1]), .clk1(clk1_v[1]),
    .dio_out(dout_v[1]), .dio_oe(oe_v[1]), .dio_in(dio_in_v[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  logic [7:0]  cmd_byte = 8'h42;
  logic [31:0] word [2];

  // timeline model state
  bit          act   [2];
  int          s_m   [2];
  logic [31:0] exp_raw  [2];
  logic [7:0]  exp_keys [2];

  // pin observation / device model state
  logic [1:0] stb_p = 2'b11;
  logic [1:0] clk1_p = 2'b11;
  logic [1:0] oe_p = 2'b00;
  int stb_falls [2];
  int stb_low   [2];
  int rises     [2];
  int oe_falls  [2];
  int rd_falls  [2];
  logic [7:0] cmd_rx [2];
  int oe_fall_cyc [2];
  int done_cnt    [2];
  int done_cyc    [2];

  function automatic int hp_of(input int i);
    return (i == 0) ? HF : 200;
  endfunction

  function automatic int wc_of(input int i);
    return (i == 0) ? WF : 200;
  endfunction

  // Length of the strobe-low window of one scan.
  function automatic int tot_of(input int i);
    return 81 * hp_of(i) + wc_of(i);
  endfunction

  // Button b lives in scan byte (b mod 4), at bit 0 for b<4 and bit 4 otherwise.
  function automatic logic [7:0] key_map(input logic [31:0] w);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < 8; b++) r[b] = w[(b % 4) * 8 + (b / 4) * 4];
    return r;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d got=0x%0h want=0x%0h", nm, i, cyc, got, exp);
    end
  endtask

  // Expected pin/status values k cycles after the start was accepted
  // (k<1 means idle). Bus timing is derived from the half-period grid.
  task automatic expect_out(input int i, input int k,
                            output logic e_stb, output logic e_busy, output logic e_done,
                            output logic e_oe, output logic e_clk1,
                            output logic e_dv, output logic e_dout);
    int h, w, p, q;
    h = hp_of(i); w = wc_of(i);
    e_stb = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_oe = 1'b0;
    e_clk1 = 1'b1; e_dv = 1'b0; e_dout = 1'b0;
    if (k >= 1 && k <= 81 * h + w) begin
      e_stb = 1'b0; e_busy = 1'b1;
      if (k <= 16 * h) begin
        e_oe = 1'b1;
        p = (k - 1) / h;
        e_clk1 = (p % 2 == 0);
        if (p >= 1) begin
          e_dv = 1'b1;
          e_dout = cmd_byte[(p - 1) / 2];
        end
      end else if (k > 16 * h + w && k <= 80 * h + w) begin
        q = k - 16 * h - w;
        p = (q - 1) / h;
        e_clk1 = (p % 2 == 0);
      end
    end else if (k == 81 * h + w + 1) begin
      e_done = 1'b1;
    end
  endtask

  // Timeline model: tracks accepted scans and the published result.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_v[i]) begin
        act[i] <= 1'b0;
        exp_raw[i] <= 32'h0;
        exp_keys[i] <= 8'h0;
      end else if (act[i]) begin
        if (cyc - s_m[i] == tot_of(i)) begin
          exp_raw[i]  <= word[i];
          exp_keys[i] <= key_map(word[i]);
        end
        if (cyc - s_m[i] == tot_of(i) + 1) act[i] <= 1'b0;
      end else if (start_v[i]) begin
        act[i] <= 1'b1;
        s_m[i] <= cyc;
      end
    end
  end

  // Device model, pin bookkeeping and the per-cycle compare.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic e_stb, e_busy, e_done, e_oe, e_clk1, e_dv, e_dout;
      int k;
      if (stb_p[i] && !stb_v[i]) begin
        stb_falls[i] <= stb_falls[i] + 1;
        stb_low[i]   <= 1;
        rises[i]     <= 0;
        oe_falls[i]  <= 0;
        rd_falls[i]  <= 0;
        cmd_rx[i]    <= 8'h00;
      end else begin
        if (!stb_v[i]) stb_low[i] <= stb_low[i] + 1;
        if (!stb_v[i] && clk1_p[i] && !clk1_v[i]) begin
          if (oe_v[i]) oe_falls[i] <= oe_falls[i] + 1;
          else begin
            rd_falls[i] <= rd_falls[i] + 1;
            dio_in_v[i] <= word[i][rd_falls[i][4:0]];
          end
        end
        if (!stb_v[i] && !clk1_p[i] && clk1_v[i] && oe_p[i]) begin
          cmd_rx[i][rises[i][2:0]] <= dout_v[i];
          rises[i] <= rises[i] + 1;
        end
      end
      if (oe_p[i] && !oe_v[i]) oe_fall_cyc[i] <= cyc;
      if (done_v[i]) begin
        done_cnt[i] <= done_cnt[i] + 1;
        done_cyc[i] <= cyc;
      end
      stb_p[i]  <= stb_v[i];
      clk1_p[i] <= clk1_v[i];
      oe_p[i]   <= oe_v[i];

      if (chk_en) begin
        k = act[i] ? (cyc - s_m[i]) : -1;
        expect_out(i, k, e_stb, e_busy, e_done, e_oe, e_clk1, e_dv, e_dout);
        chk("stb",  i, stb_v[i],  e_stb);
        chk("busy", i, busy_v[i], e_busy);
        chk("done", i, done_v[i], e_done);
        chk("dio_oe", i, oe_v[i], e_oe);
        chk("clk1", i, clk1_v[i], e_clk1);
        chk("raw",  i, raw_v[i],  exp_raw[i]);
        chk("keys", i, keys_v[i], exp_keys[i]);
        if (e_dv) chk("dio_out", i, dout_v[i], e_dout);
      end
    end
  end

  task automatic wait_done(input int i, input int budget, output int dcyc);
    int n, d0;
    n = 0;
    d0 = done_cnt[i];
    while (done_cnt[i] == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", i, (done_cnt[i] != d0), 1);
    dcyc = done_cyc[i];
  endtask

  task automatic pulse_start(input int i, output int st);
    st = cyc;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  initial begin
    int st, d1, d2, f0, n0;
    word[0] = 32'h0; word[1] = 32'h0;
    rst_v = 2'b00;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_stb", i, stb_v[i], 1);
      chk("rst_clk1", i, clk1_v[i], 1);
      chk("rst_oe", i, oe_v[i], 0);
      chk("rst_dout", i, dout_v[i], 0);
      chk("rst_raw", i, raw_v[i], 32'h0);
      chk("rst_keys", i, keys_v[i], 8'h0);
    end
    rst_v = 2'b11;
    repeat (5) @(negedge clk);

    // Framing and read data, with stray start pulses while busy.
    word[0] = 32'h1100_1001;
    f0 = stb_falls[0];
    pulse_start(0, st);
    repeat (20) @(negedge clk);
    start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
    repeat (100) @(negedge clk);
    start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
    wait_done(0, 1000, d1);
    chk("latency", 0, d1 - st, 329);
    chk("oe_fall", 0, oe_fall_cyc[0] - st, 65);
    chk("cmd_rx", 0, cmd_rx[0], 8'h42);
    chk("cmd_rises", 0, rises[0], 8);
    chk("oe_falls", 0, oe_falls[0], 8);
    chk("read_falls", 0, rd_falls[0], 32);
    chk("stb_low", 0, stb_low[0], 328);
    chk("stb_fall_cnt", 0, stb_falls[0] - f0, 1);
    chk("raw_lit", 0, raw_v[0], 32'h1100_1001);
    chk("keys_lit", 0, keys_v[0], 8'hA9);

    // Held start: back-to-back scans separated by the done cycle.
    word[0] = 32'h1000_0001;
    f0 = stb_falls[0];
    start_v[0] = 1'b1;
    wait_done(0, 1000, d1);
    repeat (20) @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, 1000, d2);
    chk("back2back", 0, d2 - d1, 330);
    chk("b2b_falls", 0, stb_falls[0] - f0, 2);
    chk("keys_81", 0, keys_v[0], 8'h81);

    // Hold between scans.
    n0 = done_cnt[0]; f0 = stb_falls[0];
    repeat (10000) @(negedge clk);
    chk("hold_keys", 0, keys_v[0], 8'h81);
    chk("hold_raw", 0, raw_v[0], 32'h1000_0001);
    chk("hold_falls", 0, stb_falls[0] - f0, 0);
    chk("hold_done", 0, done_cnt[0] - n0, 0);

    // Reset in the middle of data bit 10.
    word[0] = 32'hFFFF_FFFF;
    pulse_start(0, st);
    repeat (150) @(negedge clk);
    chk("mid_read_busy", 0, busy_v[0], 1);
    rst_v[0] = 1'b0;
    @(negedge clk);
    rst_v[0] = 1'b1;
    chk("abort_stb", 0, stb_v[0], 1);
    chk("abort_clk1", 0, clk1_v[0], 1);
    chk("abort_oe", 0, oe_v[0], 0);
    chk("abort_busy", 0, busy_v[0], 0);
    chk("abort_raw", 0, raw_v[0], 32'h0);
    chk("abort_keys", 0, keys_v[0], 8'h0);
    n0 = done_cnt[0];
    repeat (400) @(negedge clk);
    chk("abort_no_done", 0, done_cnt[0] - n0, 0);

    word[0] = 32'hA5C3_0F11;
    pulse_start(0, st);
    wait_done(0, 1000, d1);
    chk("post_rst_lat", 0, d1 - st, 329);
    chk("post_rst_raw", 0, raw_v[0], 32'hA5C3_0F11);
    chk("post_rst_keys", 0, keys_v[0], 8'h1F);

    // Default timing, device returns all zeros.
    word[1] = 32'h0;
    pulse_start(1, st);
    wait_done(1, 20000, d1);
    chk("dflt_latency", 1, d1 - st, 16401);
    chk("dflt_stb_low", 1, stb_low[1], 16400);
    chk("dflt_cmd_rx", 1, cmd_rx[1], 8'h42);
    chk("dflt_read_falls", 1, rd_falls[1], 32);
    chk("dflt_keys", 1, keys_v[1], 8'h00);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
